// File: rtl/smc_sram_ahb_if.sv
`default_nettype none
// ============================================================================
// Module   : smc_sram_ahb_if
// Purpose  : AHB-Lite slave to single-port synchronous SRAM bridge with a
//            one-entry posted-write buffer and two-cycle ERROR responses.
// Revision : 1.0
// ============================================================================
module smc_sram_ahb_if #(
    parameter int AW = 14
) (
    input  logic          pmu_smc_hclk,
    input  logic          pmu_smc_hrst,
    input  logic          hmain0_smc_hsel,
    input  logic [31:0]   hmain0_smc_haddr,
    input  logic [1:0]    hmain0_smc_htrans,
    input  logic          hmain0_smc_hwrite,
    input  logic [2:0]    hmain0_smc_hsize,
    input  logic [3:0]    hmain0_smc_hprot,
    input  logic [31:0]   hmain0_smc_hwdata,
    output logic [31:0]   smc_hmain0_hrdata,
    output logic          smc_hmain0_hready,
    output logic [1:0]    smc_hmain0_hresp,
    output logic          sram_cen,
    output logic          sram_wen,
    output logic [3:0]    sram_be,
    output logic [AW-1:0] sram_addr,
    output logic [31:0]   sram_wdata,
    input  logic [31:0]   sram_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic          dp_wr_q, dp_wr_d;
    logic          dp_rd_q, dp_rd_d;
    logic [AW-1:0] dp_addr_q, dp_addr_d;
    logic [3:0]    dp_be_q, dp_be_d;
    logic          buf_valid_q, buf_valid_d;
    logic [AW-1:0] buf_addr_q, buf_addr_d;
    logic [3:0]    buf_be_q, buf_be_d;
    logic [31:0]   buf_data_q, buf_data_d;

    logic          w_hready;
    logic [1:0]    w_hresp;
    logic          w_rd_req;
    logic          w_conflict;
    logic          w_acc;
    logic          w_legal;
    logic          w_acc_ok;
    logic          w_acc_err;
    logic          w_rd_issue;
    logic          w_load;
    logic          w_drain;
    logic [3:0]    w_be;
    logic [AW-1:0] w_addr;
    logic [31:0]   w_merge;
    logic          unused_ok;

    assign unused_ok = ^{hmain0_smc_hprot, hmain0_smc_haddr[31:AW+2], hmain0_smc_htrans[0]};
    assign w_addr    = hmain0_smc_haddr[AW+1:2];

    always_comb begin
        w_be    = 4'b0000;
        w_legal = 1'b0;
        case (hmain0_smc_hsize)
            3'd0: begin
                w_be    = 4'b0001 << hmain0_smc_haddr[1:0];
                w_legal = 1'b1;
            end
            3'd1: begin
                w_be    = 4'b0011 << {hmain0_smc_haddr[1], 1'b0};
                w_legal = !hmain0_smc_haddr[0];
            end
            3'd2: begin
                w_be    = 4'b1111;
                w_legal = (hmain0_smc_haddr[1:0] == 2'b00);
            end
            default: ;
        endcase
    end

    // A read address phase that collides with a write data phase while the
    // buffer is still occupied stalls one cycle so the old entry can drain.
    assign w_rd_req   = hmain0_smc_hsel & hmain0_smc_htrans[1] & !hmain0_smc_hwrite;
    assign w_conflict = (state_q == ST_IDLE) & dp_wr_q & buf_valid_q & w_rd_req;

    always_comb begin
        w_hready = 1'b1;
        w_hresp  = 2'b00;
        state_d  = state_q;
        case (state_q)
            ST_IDLE: w_hready = !w_conflict;
            ST_ERR1: begin
                w_hready = 1'b0;
                w_hresp  = 2'b01;
            end
            ST_ERR2: w_hresp = 2'b01;
            default: ;
        endcase

        case (state_q)
            ST_IDLE: begin
                if (w_conflict) begin
                    state_d = ST_WAIT;
                end else if (w_acc_err) begin
                    state_d = ST_ERR1;
                end
            end
            ST_WAIT, ST_ERR2: state_d = w_acc_err ? ST_ERR1 : ST_IDLE;
            ST_ERR1:          state_d = ST_ERR2;
            default:          state_d = ST_IDLE;
        endcase
    end

    assign w_acc      = hmain0_smc_hsel & hmain0_smc_htrans[1] & w_hready;
    assign w_acc_ok   = w_acc & w_legal;
    assign w_acc_err  = w_acc & !w_legal;
    assign w_rd_issue = w_acc_ok & !hmain0_smc_hwrite;
    assign w_load     = dp_wr_q & w_hready;
    assign w_drain    = buf_valid_q & !w_rd_issue;

    always_comb begin
        dp_wr_d   = dp_wr_q;
        dp_rd_d   = dp_rd_q;
        dp_addr_d = dp_addr_q;
        dp_be_d   = dp_be_q;
        if (w_hready) begin
            dp_wr_d   = w_acc_ok & hmain0_smc_hwrite;
            dp_rd_d   = w_acc_ok & !hmain0_smc_hwrite;
            dp_addr_d = w_addr;
            dp_be_d   = w_be;
        end
    end

    always_comb begin
        buf_valid_d = buf_valid_q;
        buf_addr_d  = buf_addr_q;
        buf_be_d    = buf_be_q;
        buf_data_d  = buf_data_q;
        if (w_load) begin
            buf_valid_d = 1'b1;
            buf_addr_d  = dp_addr_q;
            buf_be_d    = dp_be_q;
            buf_data_d  = hmain0_smc_hwdata;
        end else if (w_drain) begin
            buf_valid_d = 1'b0;
        end
    end

    // The port is held idle during reset so a pending posted write is dropped.
    always_comb begin
        sram_cen   = 1'b0;
        sram_wen   = 1'b0;
        sram_be    = 4'b0000;
        sram_addr  = '0;
        sram_wdata = 32'h0;
        if (!pmu_smc_hrst) begin
            if (w_rd_issue) begin
                sram_cen  = 1'b1;
                sram_addr = w_addr;
            end else if (buf_valid_q) begin
                sram_cen   = 1'b1;
                sram_wen   = 1'b1;
                sram_be    = buf_be_q;
                sram_addr  = buf_addr_q;
                sram_wdata = buf_data_q;
            end
        end
    end

    always_comb begin
        w_merge = sram_rdata;
        for (int i = 0; i < 4; i++) begin
            if (buf_valid_q && (buf_addr_q == dp_addr_q) && buf_be_q[i]) begin
                w_merge[i*8 +: 8] = buf_data_q[i*8 +: 8];
            end
        end
    end

    assign smc_hmain0_hrdata = dp_rd_q ? w_merge : 32'h0;
    assign smc_hmain0_hready = w_hready;
    assign smc_hmain0_hresp  = w_hresp;

    always_ff @(posedge pmu_smc_hclk) begin
        if (pmu_smc_hrst) begin
            state_q     <= ST_IDLE;
            dp_wr_q     <= 1'b0;
            dp_rd_q     <= 1'b0;
            dp_addr_q   <= '0;
            dp_be_q     <= 4'b0000;
            buf_valid_q <= 1'b0;
            buf_addr_q  <= '0;
            buf_be_q    <= 4'b0000;
            buf_data_q  <= 32'h0;
        end else begin
            state_q     <= state_d;
            dp_wr_q     <= dp_wr_d;
            dp_rd_q     <= dp_rd_d;
            dp_addr_q   <= dp_addr_d;
            dp_be_q     <= dp_be_d;
            buf_valid_q <= buf_valid_d;
            buf_addr_q  <= buf_addr_d;
            buf_be_q    <= buf_be_d;
            buf_data_q  <= buf_data_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_smc_sram_ahb_if.sv
`default_nettype none
// ============================================================================
// Module   : tb_smc_sram_ahb_if
// Purpose  : Directed self-checking bench for smc_sram_ahb_if with an SRAM model.
// Revision : 1.0
// ============================================================================
module tb_smc_sram_ahb_if;

    localparam int AW = 14;

    logic          clk = 1'b0;
    logic          rst;
    logic          hsel;
    logic [31:0]   haddr;
    logic [1:0]    htrans;
    logic          hwrite;
    logic [2:0]    hsize;
    logic [3:0]    hprot;
    logic [31:0]   hwdata;
    logic [31:0]   hrdata;
    logic          hready;
    logic [1:0]    hresp;
    logic          sram_cen;
    logic          sram_wen;
    logic [3:0]    sram_be;
    logic [AW-1:0] sram_addr;
    logic [31:0]   sram_wdata;
    logic [31:0]   sram_rdata;

    logic [31:0]   mem [0:(1<<AW)-1];
    int            cen_cnt = 0;
    int            checks  = 0;
    int            errors  = 0;
    int            cen0;

    smc_sram_ahb_if #(.AW(AW)) dut (
        .pmu_smc_hclk      (clk),
        .pmu_smc_hrst      (rst),
        .hmain0_smc_hsel   (hsel),
        .hmain0_smc_haddr  (haddr),
        .hmain0_smc_htrans (htrans),
        .hmain0_smc_hwrite (hwrite),
        .hmain0_smc_hsize  (hsize),
        .hmain0_smc_hprot  (hprot),
        .hmain0_smc_hwdata (hwdata),
        .smc_hmain0_hrdata (hrdata),
        .smc_hmain0_hready (hready),
        .smc_hmain0_hresp  (hresp),
        .sram_cen          (sram_cen),
        .sram_wen          (sram_wen),
        .sram_be           (sram_be),
        .sram_addr         (sram_addr),
        .sram_wdata        (sram_wdata),
        .sram_rdata        (sram_rdata)
    );

    always #5 clk = ~clk;

    // Single-port synchronous SRAM with byte write enables.
    always @(posedge clk) begin
        if (sram_cen) begin
            cen_cnt <= cen_cnt + 1;
            if (sram_wen) begin
                for (int b = 0; b < 4; b++) begin
                    if (sram_be[b]) mem[sram_addr][b*8 +: 8] <= sram_wdata[b*8 +: 8];
                end
            end else begin
                sram_rdata <= mem[sram_addr];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic bus_idle();
        hsel   = 1'b0;
        htrans = 2'b00;
        haddr  = 32'h0;
        hwrite = 1'b0;
        hsize  = 3'd2;
    endtask

    task automatic ap(input logic [31:0] a, input logic w, input logic [2:0] sz);
        hsel   = 1'b1;
        htrans = 2'b10;
        haddr  = a;
        hwrite = w;
        hsize  = sz;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_hready"}, {31'h0, hready}, 32'h1);
        chk({tag, "_hresp"},  {30'h0, hresp}, 32'h0);
        chk({tag, "_hrdata"}, hrdata, 32'h0);
        chk({tag, "_cen"},    {31'h0, sram_cen}, 32'h0);
        chk({tag, "_wen"},    {31'h0, sram_wen}, 32'h0);
        chk({tag, "_be"},     {28'h0, sram_be}, 32'h0);
        chk({tag, "_addr"},   {18'h0, sram_addr}, 32'h0);
        chk({tag, "_wdata"},  sram_wdata, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b1;
        hprot  = 4'h3;
        hwdata = 32'h0;
        bus_idle();
        repeat (2) @(posedge clk);
        mid();
        chk_reset_outputs("rst");
        tick();
        rst = 1'b0;

        // Preload: 0x40=11223344, 0x8=CAFEF00D, 0x200=55667788
        ap(32'h40, 1'b1, 3'd2);                         tick();
        ap(32'h8, 1'b1, 3'd2);   hwdata = 32'h11223344; tick();
        ap(32'h200, 1'b1, 3'd2); hwdata = 32'hCAFEF00D; tick();
        bus_idle();              hwdata = 32'h55667788; tick();
        tick();
        hsel = 1'b1; htrans = 2'b01;
        mid();
        chk("busy_hready", {31'h0, hready}, 32'h1);
        chk("busy_hresp", {30'h0, hresp}, 32'h0);
        chk("busy_cen", {31'h0, sram_cen}, 32'h0);
        chk("pre_mem40", mem[14'h10], 32'h11223344);
        chk("pre_mem8", mem[14'h2], 32'hCAFEF00D);
        chk("pre_mem200", mem[14'h80], 32'h55667788);
        tick();

        // Write 0xDEADBEEF to 0x100, then read it back immediately
        ap(32'h100, 1'b1, 3'd2);
        mid(); chk("t1_wr_hready", {31'h0, hready}, 32'h1);
        tick();
        ap(32'h100, 1'b0, 3'd2); hwdata = 32'hDEADBEEF;
        mid();
        chk("t1_rd_hready", {31'h0, hready}, 32'h1);
        chk("t1_rd_cen", {31'h0, sram_cen}, 32'h1);
        chk("t1_rd_wen", {31'h0, sram_wen}, 32'h0);
        chk("t1_rd_addr", {18'h0, sram_addr}, 32'h40);
        tick();
        bus_idle();
        mid();
        chk("t1_hready", {31'h0, hready}, 32'h1);
        chk("t1_hrdata", hrdata, 32'hDEADBEEF);
        chk("t1_drain_wen", {31'h0, sram_wen}, 32'h1);
        chk("t1_drain_addr", {18'h0, sram_addr}, 32'h40);
        chk("t1_drain_wdata", sram_wdata, 32'hDEADBEEF);
        tick();
        mid();
        chk("t1_mem", mem[14'h40], 32'hDEADBEEF);
        chk("t1_cen_idle", {31'h0, sram_cen}, 32'h0);
        tick();

        // Byte 0xAA to 0x42, then word read of 0x40
        ap(32'h42, 1'b1, 3'd0); tick();
        ap(32'h40, 1'b0, 3'd2); hwdata = 32'h00AA0000; tick();
        bus_idle();
        mid();
        chk("t2_hrdata", hrdata, 32'h11AA3344);
        chk("t2_drain_be", {28'h0, sram_be}, 32'h4);
        chk("t2_drain_wen", {31'h0, sram_wen}, 32'h1);
        tick();
        mid(); chk("t2_mem", mem[14'h10], 32'h11AA3344);
        tick();

        // Halfword 0xBEEF to 0x42
        ap(32'h42, 1'b1, 3'd1); tick();
        bus_idle(); hwdata = 32'hBEEF0000; tick();
        mid();
        chk("hw_drain_be", {28'h0, sram_be}, 32'hC);
        chk("hw_drain_wdata", sram_wdata, 32'hBEEF0000);
        tick();
        mid(); chk("hw_mem", mem[14'h10], 32'hBEEF3344);
        tick();

        // Write, write, read: one stall in the second write's data phase
        ap(32'h0, 1'b1, 3'd2); tick();
        ap(32'h4, 1'b1, 3'd2); hwdata = 32'h1;
        mid(); chk("t3_w2_hready", {31'h0, hready}, 32'h1);
        tick();
        ap(32'h8, 1'b0, 3'd2); hwdata = 32'h2;
        mid();
        chk("t3_stall_hready", {31'h0, hready}, 32'h0);
        chk("t3_stall_wen", {31'h0, sram_wen}, 32'h1);
        chk("t3_stall_addr", {18'h0, sram_addr}, 32'h0);
        chk("t3_stall_wdata", sram_wdata, 32'h1);
        tick();
        mid();
        chk("t3_wait_hready", {31'h0, hready}, 32'h1);
        chk("t3_wait_rd_cen", {31'h0, sram_cen}, 32'h1);
        chk("t3_wait_rd_wen", {31'h0, sram_wen}, 32'h0);
        chk("t3_wait_rd_addr", {18'h0, sram_addr}, 32'h2);
        tick();
        bus_idle();
        mid();
        chk("t3_rd_hready", {31'h0, hready}, 32'h1);
        chk("t3_hrdata", hrdata, 32'hCAFEF00D);
        chk("t3_drain_addr", {18'h0, sram_addr}, 32'h1);
        tick();
        mid();
        chk("t3_mem0", mem[14'h0], 32'h1);
        chk("t3_mem4", mem[14'h1], 32'h2);
        tick();

        // Misaligned word read
        ap(32'h102, 1'b0, 3'd2);
        mid();
        cen0 = cen_cnt;
        chk("t4_ap_hready", {31'h0, hready}, 32'h1);
        chk("t4_ap_cen", {31'h0, sram_cen}, 32'h0);
        tick();
        bus_idle();
        mid();
        chk("t4_err1_hready", {31'h0, hready}, 32'h0);
        chk("t4_err1_hresp", {30'h0, hresp}, 32'h1);
        tick();
        mid();
        chk("t4_err2_hready", {31'h0, hready}, 32'h1);
        chk("t4_err2_hresp", {30'h0, hresp}, 32'h1);
        tick();
        mid();
        chk("t4_after_hresp", {30'h0, hresp}, 32'h0);
        chk("t4_no_cen", cen_cnt, cen0);
        tick();

        // Illegal size write
        ap(32'h300, 1'b1, 3'd3);
        mid(); cen0 = cen_cnt;
        tick();
        bus_idle(); hwdata = 32'hBAD0BAD0;
        mid();
        chk("t5_err1_hready", {31'h0, hready}, 32'h0);
        chk("t5_err1_hresp", {30'h0, hresp}, 32'h1);
        tick();
        mid();
        chk("t5_err2_hready", {31'h0, hready}, 32'h1);
        chk("t5_err2_hresp", {30'h0, hresp}, 32'h1);
        tick();
        mid();
        chk("t5_no_cen", cen_cnt, cen0);
        tick();

        // Reset while a posted write is pending
        ap(32'h200, 1'b1, 3'd2); tick();
        bus_idle(); hwdata = 32'h99999999; tick();
        rst = 1'b1;
        mid(); chk("t6_rst_cen", {31'h0, sram_cen}, 32'h0);
        tick();
        rst = 1'b0;
        mid(); chk_reset_outputs("t6");
        tick();
        ap(32'h200, 1'b0, 3'd2);
        mid();
        chk("t6_rd_cen", {31'h0, sram_cen}, 32'h1);
        chk("t6_rd_addr", {18'h0, sram_addr}, 32'h80);
        tick();
        bus_idle();
        mid();
        chk("t6_hrdata", hrdata, 32'h55667788);
        chk("t6_mem", mem[14'h80], 32'h55667788);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
